micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Parametrised microprogrammed control unit for the multicycle MIPS datapath. It holds a writable control store and two writable opcode-dispatch tables, and steps a micro-PC (uPC) through the microprogram. It decodes the current microword's 3-bit encoded field into datapath strobes and passes raw control bits through. It sits between the instruction register (opcode input) and the datapath/memory control pins.

## Interface
Parameters:
- UPC_W, 4: uPC width; control store depth 2^UPC_W.
- OP_W, 6: opcode width; each dispatch table has 2^OP_W entries.
- RAW_W, 8: raw pass-through control bits per microword.
- Derived MW_W = 2 + RAW_W + 3: microword = {seq[1:0], raw[RAW_W-1:0], code[2:0]}.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- run  in  1  1 = sequence; 0 = halted, uPC held at 0.
- stall  in  1  memory not ready; holds uPC.
- opcode  in  OP_W  IR opcode field used for dispatch.
- prog_we  in  1  programming write strobe.
- prog_sel  in  2  0 = control store, 1 = dispatch 1, 2 = dispatch 2, 3 = reserved.
- prog_addr  in  max(UPC_W,OP_W)  write address; upper bits ignored for the store.
- prog_data  in  max(MW_W,UPC_W+1)  store: low MW_W bits; dispatch: {valid, target[UPC_W-1:0]}.
- upc  out  UPC_W  current micro-PC.
- MemWr, IRWr, MemtoReg, RegDst  out  1 each  decoded strobes.
- PCSrc  out  2  decoded PC source.
- ctl_raw  out  RAW_W  raw field of current microword.
- illegal_op  out  1  one-cycle pulse on a dispatch miss.
- prog_err  out  1  one-cycle pulse on a rejected write.

## Operation
- Code field decode, {MemWr,IRWr,MemtoReg,PCSrc,RegDst}:
  - 001 → 000001
  - 010 → 000010
  - 011 → 000100
  - 100 → 001000
  - 101 → 100000
  - 110 → 010000
  - 000 and 111 → all zero.
- Seq field selects the next uPC:
  - 00 NEXT: uPC+1, wraps modulo 2^UPC_W.
  - 01 DISP1: dispatch table 1 indexed by opcode.
  - 10 DISP2: dispatch table 2 indexed by opcode.
  - 11 FETCH: 0.
- Dispatch miss (valid=0 entry): next uPC = 0; illegal_op = 1 for that cycle only.
- stall=1: uPC holds, illegal_op suppressed, IRWr forced to 0. MemWr, MemtoReg, PCSrc, RegDst and ctl_raw follow the microword.
- run=0: uPC = 0. All decoded outputs and ctl_raw = 0. illegal_op = 0.
- Programming:
  - Accepted only when run=0.
  - prog_we with run=1 or prog_sel=3 writes nothing and pulses prog_err the next cycle.
  - A write is visible to reads from the following cycle.
- Contents: rst does not clear the control store or dispatch tables. Their contents are undefined until written; dispatch valid bits clear on rst.

## Timing
- Control store and dispatch reads are combinational from the uPC register. Outputs for address A are valid during the cycle upc = A.
- uPC updates on the rising edge when run=1 and stall=0. Each non-stalled microinstruction takes one cycle.
- Dispatch uses the opcode sampled in the same cycle as the DISP microword.
- Reset values: upc=0, all strobes 0, ctl_raw 0, illegal_op 0, prog_err 0. Reset during run returns to uPC 0 on the next edge.
- rst has priority over run/stall/prog_we. stall has priority over sequencing.
- prog_we coinciding with run=1 is rejected even in the cycle run rises.

## Structure
- Package mseq_pkg holds:
  - seq encodings SEQ_NEXT/SEQ_DISP1/SEQ_DISP2/SEQ_FETCH;
  - prog_sel constants SEL_STORE/SEL_D1/SEL_D2;
  - code-field constants;
  - a microword field-slicing function parametrised by RAW_W.
- Sub-module ctl_field_decode: purely combinational code→strobe mapping, instantiated once, with output gating applied in the parent.
- Storage is flop/LUT arrays with combinational read; no block RAM.

## Test plan
- Reset: assert rst with run=1 → upc=0, all outputs 0, illegal_op=0, prog_err=0.
- Linear program: load words at 0..2 with seq=NEXT, codes 001/010/011; run → RegDst, then PCSrc=01, then PCSrc=10 on consecutive cycles; the word at 2^UPC_W−1 with NEXT wraps to 0.
- Dispatch: DISP1 at uPC 1; table 1 entry opcode 0x23 = {1,5}; opcode=0x23 → upc=5 next cycle. Entry with valid=0 → upc=0 and a single illegal_op pulse.
- Stall: microword code 110 with stall high for 3 cycles → upc constant, IRWr=0 throughout; IRWr=1 in the cycle stall drops, then the uPC advances.
- Program protection: prog_we while run=1, or with prog_sel=3 → prog_err pulses, store contents unchanged on readback run.
- Mid-run reset: rst asserted at uPC 3 → upc=0 next cycle and store contents preserved.

Source files
------------

// File: rtl/mseq_pkg.sv
// ---------------------------------------------------------------------------
// mseq_pkg : shared encodings and microword field helpers for micro_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mseq_pkg;

   typedef enum logic [1:0] {
      SEQ_NEXT  = 2'b00,
      SEQ_DISP1 = 2'b01,
      SEQ_DISP2 = 2'b10,
      SEQ_FETCH = 2'b11
   } seq_e;

   localparam logic [1:0] SEL_STORE = 2'd0;
   localparam logic [1:0] SEL_D1    = 2'd1;
   localparam logic [1:0] SEL_D2    = 2'd2;
   localparam logic [1:0] SEL_RSVD  = 2'd3;

   localparam logic [2:0] CODE_NOP        = 3'b000;
   localparam logic [2:0] CODE_REG_DST    = 3'b001;
   localparam logic [2:0] CODE_PC_SRC1    = 3'b010;
   localparam logic [2:0] CODE_PC_SRC2    = 3'b011;
   localparam logic [2:0] CODE_MEM_TO_REG = 3'b100;
   localparam logic [2:0] CODE_MEM_WR     = 3'b101;
   localparam logic [2:0] CODE_IR_WR      = 3'b110;
   localparam logic [2:0] CODE_RSVD       = 3'b111;

   // Callers zero-extend the microword to MW_MAX and truncate the result.
   localparam int unsigned MW_MAX = 64;

   function automatic seq_e mw_seq(input logic [MW_MAX-1:0] mw, input int unsigned raw_w);
      return seq_e'(2'(mw >> (raw_w + 3)));
   endfunction

   function automatic logic [2:0] mw_code(input logic [MW_MAX-1:0] mw);
      return 3'(mw);
   endfunction

   function automatic logic [MW_MAX-1:0] mw_raw(input logic [MW_MAX-1:0] mw, input int unsigned raw_w);
      return (mw >> 3) & ((64'(1) << raw_w) - 64'(1));
   endfunction

endpackage

`default_nettype wire

// File: rtl/ctl_field_decode.sv
// ---------------------------------------------------------------------------
// ctl_field_decode : maps the 3-bit microword code field onto datapath strobes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctl_field_decode
   import mseq_pkg::*;
(
   input  logic [2:0] code_i,
   output logic       mem_wr_o,
   output logic       ir_wr_o,
   output logic       memto_reg_o,
   output logic [1:0] pc_src_o,
   output logic       reg_dst_o
);

   always_comb begin
      mem_wr_o    = 1'b0;
      ir_wr_o     = 1'b0;
      memto_reg_o = 1'b0;
      pc_src_o    = 2'b00;
      reg_dst_o   = 1'b0;
      case (code_i)
         CODE_REG_DST:    reg_dst_o   = 1'b1;
         CODE_PC_SRC1:    pc_src_o    = 2'b01;
         CODE_PC_SRC2:    pc_src_o    = 2'b10;
         CODE_MEM_TO_REG: memto_reg_o = 1'b1;
         CODE_MEM_WR:     mem_wr_o    = 1'b1;
         CODE_IR_WR:      ir_wr_o     = 1'b1;
         default:         ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer : writable-control-store microsequencer for a multicycle MIPS
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module micro_sequencer
   import mseq_pkg::*;
#(
   parameter  int UPC_W = 4,
   parameter  int OP_W  = 6,
   parameter  int RAW_W = 8,
   localparam int MW_W  = 2 + RAW_W + 3,
   localparam int AW    = (UPC_W > OP_W) ? UPC_W : OP_W,
   localparam int DW    = (MW_W > UPC_W + 1) ? MW_W : UPC_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             stall,
   input  logic [OP_W-1:0]  opcode,
   input  logic             prog_we,
   input  logic [1:0]       prog_sel,
   input  logic [AW-1:0]    prog_addr,
   input  logic [DW-1:0]    prog_data,
   output logic [UPC_W-1:0] upc,
   output logic             MemWr,
   output logic             IRWr,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic [1:0]       PCSrc,
   output logic [RAW_W-1:0] ctl_raw,
   output logic             illegal_op,
   output logic             prog_err
);

   logic [UPC_W-1:0] upc_q, upc_d;
   logic             prog_err_q;
   logic [MW_W-1:0]  store_q [2**UPC_W];

   logic             w_wr_ok;
   logic             w_active;
   logic [MW_W-1:0]  w_mw;
   seq_e             w_seq;
   logic [2:0]       w_code;
   logic [RAW_W-1:0] w_raw;
   logic [UPC_W-1:0] w_seq_next;
   logic             w_miss;
   logic [UPC_W-1:0] w_disp_tgt [2];
   logic [1:0]       w_disp_vld;

   logic             w_dec_mem_wr, w_dec_ir_wr, w_dec_memto_reg, w_dec_reg_dst;
   logic [1:0]       w_dec_pc_src;

   // Writes land only while halted; rst also blocks them so it wins over prog_we.
   assign w_wr_ok  = prog_we & ~run & ~rst & (prog_sel != SEL_RSVD);
   assign w_active = run & ~rst;

   always_ff @(posedge clk) begin
      if (w_wr_ok && prog_sel == SEL_STORE) begin
         store_q[prog_addr[UPC_W-1:0]] <= prog_data[MW_W-1:0];
      end
   end

   for (genvar t = 0; t < 2; t++) begin : g_disp
      logic [UPC_W-1:0]   tgt_q [2**OP_W];
      logic [2**OP_W-1:0] vld_q;
      logic               w_we;

      assign w_we = w_wr_ok & (prog_sel == ((t == 0) ? SEL_D1 : SEL_D2));

      always_ff @(posedge clk) begin
         if (w_we) begin
            tgt_q[prog_addr[OP_W-1:0]] <= prog_data[UPC_W-1:0];
         end
      end

      // Only the valid bits are reset; targets keep whatever was last written.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= '0;
         end else if (w_we) begin
            vld_q[prog_addr[OP_W-1:0]] <= prog_data[UPC_W];
         end
      end

      assign w_disp_tgt[t] = tgt_q[opcode];
      assign w_disp_vld[t] = vld_q[opcode];
   end

   assign w_mw   = store_q[upc_q];
   assign w_seq  = mw_seq(MW_MAX'(w_mw), RAW_W);
   assign w_code = mw_code(MW_MAX'(w_mw));
   assign w_raw  = RAW_W'(mw_raw(MW_MAX'(w_mw), RAW_W));

   always_comb begin
      w_seq_next = '0;
      w_miss     = 1'b0;
      case (w_seq)
         SEQ_NEXT:  w_seq_next = upc_q + 1'b1;
         SEQ_DISP1: begin
            if (w_disp_vld[0]) w_seq_next = w_disp_tgt[0];
            else               w_miss     = 1'b1;
         end
         SEQ_DISP2: begin
            if (w_disp_vld[1]) w_seq_next = w_disp_tgt[1];
            else               w_miss     = 1'b1;
         end
         default:   w_seq_next = '0;
      endcase
   end

   always_comb begin
      upc_d = upc_q;
      if (!run) begin
         upc_d = '0;
      end else if (!stall) begin
         upc_d = w_seq_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         upc_q      <= '0;
         prog_err_q <= 1'b0;
      end else begin
         upc_q      <= upc_d;
         prog_err_q <= prog_we & (run | (prog_sel == SEL_RSVD));
      end
   end

   ctl_field_decode u_dec (
      .code_i      (w_code),
      .mem_wr_o    (w_dec_mem_wr),
      .ir_wr_o     (w_dec_ir_wr),
      .memto_reg_o (w_dec_memto_reg),
      .pc_src_o    (w_dec_pc_src),
      .reg_dst_o   (w_dec_reg_dst)
   );

   // A stalled IR write would latch a not-yet-valid memory word, so IRWr is masked.
   assign upc        = upc_q;
   assign MemWr      = w_active & w_dec_mem_wr;
   assign IRWr       = w_active & ~stall & w_dec_ir_wr;
   assign MemtoReg   = w_active & w_dec_memto_reg;
   assign RegDst     = w_active & w_dec_reg_dst;
   assign PCSrc      = {2{w_active}} & w_dec_pc_src;
   assign ctl_raw    = {RAW_W{w_active}} & w_raw;
   assign illegal_op = w_active & ~stall & w_miss;
   assign prog_err   = prog_err_q;

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer : directed self-checking bench for micro_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_micro_sequencer;
   import mseq_pkg::*;

   logic        clk = 1'b0;
   logic        rst, run, stall, prog_we;
   logic [5:0]  opcode, prog_addr;
   logic [1:0]  prog_sel;
   logic [12:0] prog_data;
   logic [3:0]  upc;
   logic        MemWr, IRWr, MemtoReg, RegDst, illegal_op, prog_err;
   logic [1:0]  PCSrc;
   logic [7:0]  ctl_raw;
   wire  [5:0]  strb = {MemWr, IRWr, MemtoReg, PCSrc, RegDst};

   int n_chk  = 0;
   int n_pass = 0;

   micro_sequencer #(.UPC_W(4), .OP_W(6), .RAW_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .stall      (stall),
      .opcode     (opcode),
      .prog_we    (prog_we),
      .prog_sel   (prog_sel),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .upc        (upc),
      .MemWr      (MemWr),
      .IRWr       (IRWr),
      .MemtoReg   (MemtoReg),
      .RegDst     (RegDst),
      .PCSrc      (PCSrc),
      .ctl_raw    (ctl_raw),
      .illegal_op (illegal_op),
      .prog_err   (prog_err)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] mw(input logic [1:0] s, input logic [7:0] r, input logic [2:0] c);
      return {s, r, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_out(input string tag, input logic [3:0] e_upc, input logic [5:0] e_strb,
                          input logic [7:0] e_raw);
      chk({tag, "_upc"}, 32'(upc), 32'(e_upc));
      chk({tag, "_strb"}, 32'(strb), 32'(e_strb));
      chk({tag, "_raw"}, 32'(ctl_raw), 32'(e_raw));
   endtask

   task automatic prog(input logic [1:0] sel, input logic [5:0] addr, input logic [12:0] data);
      prog_sel  = sel;
      prog_addr = addr;
      prog_data = data;
      prog_we   = 1'b1;
      tick();
      prog_we   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b1; stall = 1'b0; prog_we = 1'b0;
      opcode = 6'h00; prog_sel = SEL_STORE; prog_addr = '0; prog_data = '0;

      // Reset with run high
      tick(); tick();
      chk_out("reset", 4'd0, 6'b000000, 8'h00);
      chk("reset_illegal", 32'(illegal_op), 32'd0);
      chk("reset_prog_err", 32'(prog_err), 32'd0);

      rst = 1'b0; run = 1'b0;
      tick();
      prog(SEL_STORE, 6'd0,  mw(SEQ_NEXT,  8'hA1, 3'b001));
      prog(SEL_STORE, 6'd1,  mw(SEQ_NEXT,  8'hB2, 3'b010));
      prog(SEL_STORE, 6'd2,  mw(SEQ_NEXT,  8'hC3, 3'b011));
      prog(SEL_STORE, 6'd3,  mw(SEQ_FETCH, 8'h3C, 3'b100));
      prog(SEL_STORE, 6'd5,  mw(SEQ_DISP2, 8'h55, 3'b101));
      prog(SEL_STORE, 6'd15, mw(SEQ_NEXT,  8'hF0, 3'b110));
      prog(SEL_D1, 6'h23, 13'h15);
      prog(SEL_D2, 6'h23, 13'h1F);
      chk("halted_prog_err", 32'(prog_err), 32'd0);
      chk_out("halted", 4'd0, 6'b000000, 8'h00);

      // Linear run, FETCH back to 0
      run = 1'b1; #1;
      chk_out("lin0", 4'd0, 6'b000001, 8'hA1);
      tick(); chk_out("lin1", 4'd1, 6'b000010, 8'hB2);
      tick(); chk_out("lin2", 4'd2, 6'b000100, 8'hC3);
      tick(); chk_out("lin3", 4'd3, 6'b001000, 8'h3C);
      tick(); chk_out("fetch", 4'd0, 6'b000001, 8'hA1);

      // Dispatch: 0 -> 1 (DISP1) -> 5 (DISP2) -> 15 -> wrap 0
      run = 1'b0; tick();
      prog(SEL_STORE, 6'd1, mw(SEQ_DISP1, 8'hB2, 3'b010));
      opcode = 6'h23; run = 1'b1; #1;
      chk("d_start_upc", 32'(upc), 32'd0);
      tick(); chk_out("disp1_at", 4'd1, 6'b000010, 8'hB2);
      chk("disp1_illegal", 32'(illegal_op), 32'd0);
      tick(); chk_out("disp1_tgt", 4'd5, 6'b100000, 8'h55);
      tick(); chk_out("disp2_tgt", 4'd15, 6'b010000, 8'hF0);

      // Stall on an IR-write microword
      stall = 1'b1; #1;
      chk_out("stall0", 4'd15, 6'b000000, 8'hF0);
      tick(); chk_out("stall1", 4'd15, 6'b000000, 8'hF0);
      tick(); chk_out("stall2", 4'd15, 6'b000000, 8'hF0);
      stall = 1'b0; #1;
      chk_out("unstall", 4'd15, 6'b010000, 8'hF0);
      tick(); chk_out("wrap", 4'd0, 6'b000001, 8'hA1);

      // Dispatch miss, with a stalled cycle in between
      opcode = 6'h24;
      tick(); chk("miss_upc", 32'(upc), 32'd1);
      chk("miss_pulse", 32'(illegal_op), 32'd1);
      stall = 1'b1; #1;
      chk("miss_stall_supp", 32'(illegal_op), 32'd0);
      tick(); chk("miss_stall_upc", 32'(upc), 32'd1);
      stall = 1'b0; #1;
      chk("miss_pulse2", 32'(illegal_op), 32'd1);
      tick(); chk("miss_to0_upc", 32'(upc), 32'd0);
      chk("miss_to0_illegal", 32'(illegal_op), 32'd0);

      // Protection: write in the cycle run rises, then reserved select
      run = 1'b0; tick();
      run = 1'b1;
      prog(SEL_STORE, 6'd0, mw(SEQ_NEXT, 8'hEE, 3'b101));
      chk("perr_run", 32'(prog_err), 32'd1);
      tick(); chk("perr_run_clr", 32'(prog_err), 32'd0);
      run = 1'b0; tick();
      prog(SEL_RSVD, 6'd0, mw(SEQ_NEXT, 8'hEE, 3'b101));
      chk("perr_rsvd", 32'(prog_err), 32'd1);
      tick(); chk("perr_rsvd_clr", 32'(prog_err), 32'd0);
      run = 1'b1; #1;
      chk_out("readback", 4'd0, 6'b000001, 8'hA1);

      // Mid-run reset at uPC 3
      run = 1'b0; tick();
      prog(SEL_STORE, 6'd1, mw(SEQ_NEXT, 8'hB2, 3'b010));
      run = 1'b1; #1;
      tick(); tick(); tick();
      chk_out("pre_rst", 4'd3, 6'b001000, 8'h3C);
      rst = 1'b1;
      tick(); chk_out("in_rst", 4'd0, 6'b000000, 8'h00);
      rst = 1'b0; #1;
      chk_out("post_rst", 4'd0, 6'b000001, 8'hA1);
      tick(); chk_out("post_rst1", 4'd1, 6'b000010, 8'hB2);

      // Dispatch valid bits were cleared by that reset
      run = 1'b0; tick();
      prog(SEL_STORE, 6'd1, mw(SEQ_DISP1, 8'hB2, 3'b010));
      opcode = 6'h23; run = 1'b1;
      tick(); chk("vclr_upc", 32'(upc), 32'd1);
      chk("vclr_illegal", 32'(illegal_op), 32'd1);
      tick(); chk("vclr_to0", 32'(upc), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
